// File: rtl/rc4_host_pkg.sv
// rc4_host_pkg: shared types and constants for the RC4 host controller.
//   - state_e     : controller states (IDLE, KEY, ENC, DEC, FIN)
//   - *_DEF       : default key length, message depth and index width
//   - WDOG_LIMIT  : watchdog terminal count (used only with RC4_HOST_TIMEOUT_EN)
package rc4_host_pkg;

    localparam int          KEY_LEN_DEF = 32;
    localparam int          MAX_LEN_DEF = 2048;
    localparam int          ADDR_W_DEF  = 11;
    localparam logic [19:0] WDOG_LIMIT  = 20'hFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_ENC,
        ST_DEC,
        ST_FIN
    } state_e;

endpackage

// File: rtl/rc4_host_byte_ram.sv
// rc4_host_byte_ram: single-write-port, single-registered-read-port byte RAM.
// Contents are never reset. A read and a write to the same address in the
// same cycle return the old contents.
//   clk      in   clock
//   we_i     in   write strobe
//   waddr_i  in   write address
//   wdata_i  in   write byte
//   raddr_i  in   read address (data appears the following cycle)
//   rdata_o  out  registered read byte
module rc4_host_byte_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rc4_host.sv
// rc4_host: host-side controller / self-check harness for the RC4 core.
// Streams the key, serves plaintext, buffers ciphertext, replays it, and
// compares the recovered plaintext against the original message.
// Optional macro RC4_HOST_TIMEOUT_EN adds a 20-bit handshake watchdog that
// forces FIN with fail set when the core stalls in KEY/ENC/DEC.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we/sel/addr/wdata         IDLE-only config writes (sel 0 key, 1 msg)
//   msg_len, start                run length (1..MAX_LEN) and start pulse
//   key_valid, key_in             key byte stream to core
//   plain_in_valid/plain_in/plain_read     plaintext source
//   cipher_write/cipher_out               ciphertext capture
//   cipher_in_valid/cipher_in/cipher_read  ciphertext replay
//   plain_write/plain_out                  recovered plaintext capture
//   done                          core finished decode
//   busy, pass, fail, mismatch_cnt  status
module rc4_host
    import rc4_host_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_wdata,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              start,
    output logic              key_valid,
    output logic [7:0]        key_in,
    output logic              plain_in_valid,
    output logic [7:0]        plain_in,
    input  logic              plain_read,
    input  logic              cipher_write,
    input  logic [7:0]        cipher_out,
    output logic              cipher_in_valid,
    output logic [7:0]        cipher_in,
    input  logic              cipher_read,
    input  logic              plain_write,
    input  logic [7:0]        plain_out,
    input  logic              done,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W:0]   mismatch_cnt
);

    localparam int              KW      = $clog2(KEY_LEN);
    localparam logic [KW-1:0]   K_LAST  = KW'(KEY_LEN - 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, rd_q, rd_d, wr_q, wr_d, mcnt_q, mcnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic              busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic              key_we, msg_we, cbuf_we, timeout;
    logic [7:0]        key_rd, msg_rd, cbuf_rd;
    logic [ADDR_W-1:0] msg_raddr;
    logic              unused_cfg_hi;

    assign unused_cfg_hi = ^cfg_addr[ADDR_W-1:KW];

    // RAM reads are registered, so addresses come from next-state pointers:
    // the byte for the pointer value of cycle N+1 is on rdata in cycle N+1.
    // The message RAM serves plaintext in ENC and the compare byte in DEC.
    assign msg_raddr = (state_d == ST_DEC) ? wr_d[ADDR_W-1:0] : rd_d[ADDR_W-1:0];

    rc4_host_byte_ram #(.DEPTH(KEY_LEN), .AW(KW)) u_key (
        .clk(clk), .we_i(key_we), .waddr_i(cfg_addr[KW-1:0]), .wdata_i(cfg_wdata),
        .raddr_i(k_d), .rdata_o(key_rd)
    );

    rc4_host_byte_ram #(.DEPTH(MAX_LEN), .AW(ADDR_W)) u_msg (
        .clk(clk), .we_i(msg_we), .waddr_i(cfg_addr), .wdata_i(cfg_wdata),
        .raddr_i(msg_raddr), .rdata_o(msg_rd)
    );

    rc4_host_byte_ram #(.DEPTH(MAX_LEN), .AW(ADDR_W)) u_cbuf (
        .clk(clk), .we_i(cbuf_we), .waddr_i(wr_q[ADDR_W-1:0]), .wdata_i(cipher_out),
        .raddr_i(rd_d[ADDR_W-1:0]), .rdata_o(cbuf_rd)
    );

`ifdef RC4_HOST_TIMEOUT_EN
    logic [19:0] wdog_q, wdog_d;
    logic        active, hs_evt;

    assign active  = (state_q == ST_KEY) || (state_q == ST_ENC) || (state_q == ST_DEC);
    assign hs_evt  = plain_read | cipher_write | cipher_read | plain_write | done;
    assign timeout = active && (wdog_q == WDOG_LIMIT);

    always_comb begin
        wdog_d = wdog_q;
        if (!active || hs_evt) wdog_d = '0;
        else if (!timeout)     wdog_d = wdog_q + 20'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        k_d     = k_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        mcnt_d  = mcnt_q;
        key_we  = 1'b0;
        msg_we  = 1'b0;
        cbuf_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                key_we = cfg_we && !cfg_sel;
                msg_we = cfg_we && cfg_sel;
                if (start) begin
                    pass_d = 1'b0;
                    mcnt_d = '0;
                    rd_d   = '0;
                    wr_d   = '0;
                    k_d    = '0;
                    if (msg_len == '0 || msg_len > LEN_MAX) begin
                        fail_d = 1'b1;
                    end else begin
                        fail_d  = 1'b0;
                        len_d   = msg_len;
                        busy_d  = 1'b1;
                        state_d = ST_KEY;
                    end
                end
            end
            ST_KEY: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) state_d = ST_ENC;
            end
            ST_ENC: begin
                if (plain_read && rd_q < len_q) rd_d = rd_q + 1'b1;
                if (cipher_write) begin
                    if (wr_q < len_q) begin
                        cbuf_we = 1'b1;
                        wr_d    = wr_q + 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
                if (rd_q == len_q && wr_q == len_q) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = ST_DEC;
                end
            end
            ST_DEC: begin
                if (cipher_read && rd_q < len_q) rd_d = rd_q + 1'b1;
                if (plain_write) begin
                    if (wr_q < len_q) begin
                        wr_d = wr_q + 1'b1;
                        if (plain_out != msg_rd) begin
                            fail_d = 1'b1;
                            if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
                        end
                    end else begin
                        fail_d = 1'b1;
                    end
                end
                if (done) state_d = ST_FIN;
            end
            ST_FIN: begin
                // a decode that ends before every byte came back is a failure
                if (wr_q != len_q) fail_d = 1'b1;
                pass_d  = !(fail_q || (wr_q != len_q));
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            fail_d  = 1'b1;
            state_d = ST_FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Data outputs are gated by their valids so they read 0 whenever idle,
    // including the cycle after reset (RAM read registers are not reset).
    assign key_valid       = (state_q == ST_KEY);
    assign key_in          = key_valid ? key_rd : 8'h00;
    assign plain_in_valid  = (state_q == ST_ENC) && (rd_q < len_q);
    assign plain_in        = plain_in_valid ? msg_rd : 8'h00;
    assign cipher_in_valid = (state_q == ST_DEC) && (rd_q < len_q);
    assign cipher_in       = cipher_in_valid ? cbuf_rd : 8'h00;
    assign busy            = busy_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign mismatch_cnt    = mcnt_q;

endmodule

// File: tb/tb_rc4_host.sv
// tb_rc4_host: randomized self-check of rc4_host driven by a stub RC4 core
// that XORs every byte with a fixed mask. Expected key stream, ciphertext
// buffer and final status come from the message/key arrays and the stub's
// chosen faults (corruption, overflow, early done).
module tb_rc4_host;

    localparam int AW   = 11;
    localparam int MAXL = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we, cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_wdata;
    logic [AW:0]   msg_len;
    logic          start;
    logic          key_valid;
    logic [7:0]    key_in;
    logic          plain_in_valid;
    logic [7:0]    plain_in;
    logic          plain_read, cipher_write;
    logic [7:0]    cipher_out;
    logic          cipher_in_valid;
    logic [7:0]    cipher_in;
    logic          cipher_read, plain_write;
    logic [7:0]    plain_out;
    logic          done, busy, pass, fail;
    logic [AW:0]   mismatch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] key_m [32];
    logic [7:0] msg_m [MAXL];

    always #5 clk = ~clk;

    rc4_host dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .msg_len(msg_len), .start(start),
        .key_valid(key_valid), .key_in(key_in),
        .plain_in_valid(plain_in_valid), .plain_in(plain_in), .plain_read(plain_read),
        .cipher_write(cipher_write), .cipher_out(cipher_out),
        .cipher_in_valid(cipher_in_valid), .cipher_in(cipher_in), .cipher_read(cipher_read),
        .plain_write(plain_write), .plain_out(plain_out),
        .done(done), .busy(busy), .pass(pass), .fail(fail), .mismatch_cnt(mismatch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // write key_m[0..31] and msg_m[0..n-1] into the DUT RAMs
    task automatic load(input int n);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(i); cfg_wdata = key_m[i];
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = AW'(i); cfg_wdata = msg_m[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One full run against the stub core. corrupt: index of decoded byte to
    // flip bit 0 (-1 none); extra: surplus cipher writes; early: done after n-1.
    task automatic run(input string nm, input int n, input logic [7:0] xk,
                       input int corrupt, input int extra, input bit early);
        logic [7:0] q[$];
        logic [7:0] dq[$];
        int kc, rds, wrs, xtra, crd, pwr, cyc, tgt, bud, exp_mm;
        bit exp_fail;
        @(negedge clk);
        msg_len = (AW+1)'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_start"}, busy, 1);
        kc = 0;
        while (key_valid && kc < 40) begin
            chk({nm, "_key_byte"}, key_in, key_m[kc]);
            kc++;
            @(negedge clk);
        end
        chk({nm, "_key_cycles"}, kc, 32);

        rds = 0; wrs = 0; xtra = extra; cyc = 0; bud = 40 * n + 200;
        while (!cipher_in_valid && cyc < bud) begin
            plain_read = 1'b0; cipher_write = 1'b0;
            if (plain_in_valid && $urandom_range(0, 1) == 1) begin
                chk({nm, "_plain_in"}, plain_in, msg_m[rds]);
                plain_read = 1'b1; q.push_back(plain_in); rds++;
            end
            if (extra == 0) begin
                if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    cipher_write = 1'b1; cipher_out = q.pop_front() ^ xk; wrs++;
                end
            end else if (rds == n) begin
                if (q.size() > 0) begin
                    cipher_write = 1'b1; cipher_out = q.pop_front() ^ xk; wrs++;
                end else if (xtra > 0) begin
                    cipher_write = 1'b1; cipher_out = 8'($urandom); xtra--;
                end
            end
            @(negedge clk);
            cyc++;
        end
        plain_read = 1'b0; cipher_write = 1'b0;
        chk({nm, "_enc_bound"}, (cyc < bud), 1);

        crd = 0; pwr = 0; cyc = 0;
        tgt = early ? n - 1 : n;
        while (pwr < tgt && cyc < bud) begin
            cipher_read = 1'b0; plain_write = 1'b0;
            if (cipher_in_valid && $urandom_range(0, 1) == 1) begin
                chk({nm, "_cbuf"}, cipher_in, msg_m[crd] ^ xk);
                cipher_read = 1'b1; dq.push_back(cipher_in ^ xk); crd++;
            end
            if (dq.size() > 0 && $urandom_range(0, 1) == 1) begin
                plain_write = 1'b1; plain_out = dq.pop_front();
                if (pwr == corrupt) plain_out = plain_out ^ 8'h01;
                pwr++;
            end
            @(negedge clk);
            cyc++;
        end
        cipher_read = 1'b0; plain_write = 1'b0;
        chk({nm, "_dec_bound"}, (cyc < bud), 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_busy_end"}, busy, 0);

        exp_mm   = (corrupt >= 0 && corrupt < tgt) ? 1 : 0;
        exp_fail = (exp_mm != 0) || (extra > 0) || early;
        chk({nm, "_pass"}, pass, !exp_fail);
        chk({nm, "_fail"}, fail, exp_fail);
        chk({nm, "_mcnt"}, mismatch_cnt, exp_mm);
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < 32; i++) key_m[i] = 8'($urandom);
        for (int i = 0; i < n; i++)  msg_m[i] = 8'($urandom);
    endtask

    initial begin
        int n, c;
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        msg_len = '0; start = 1'b0; plain_read = 1'b0; cipher_write = 1'b0;
        cipher_out = '0; cipher_read = 1'b0; plain_write = 1'b0; plain_out = '0; done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid,
                              busy, pass, fail}, 0);
        chk("reset_cin_mcnt", {cipher_in, mismatch_cnt}, 0);

        // directed: counting key, XOR-0x5A loopback
        for (int i = 0; i < 32; i++) key_m[i] = 8'(i);
        msg_m[0] = 8'h11; msg_m[1] = 8'h22; msg_m[2] = 8'h33; msg_m[3] = 8'h44;
        load(4);
        run("loop", 4, 8'h5A, -1, 0, 1'b0);
        run("corrupt", 4, 8'h5A, 2, 0, 1'b0);

        msg_m[0] = 8'hA5; msg_m[1] = 8'h3C;
        load(2);
        run("overflow", 2, 8'h0F, -1, 1, 1'b0);

        rand_data(5);
        load(5);
        run("short", 5, 8'hC3, -1, 0, 1'b1);

        // out-of-range lengths are rejected without leaving IDLE
        @(negedge clk); msg_len = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("len0_fail", fail, 1);
        chk("len0_busy", busy, 0);
        @(negedge clk);
        chk("len0_idle", key_valid, 0);
        @(negedge clk); msg_len = (AW+1)'(MAXL + 1); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("lenbig_fail", fail, 1);
        chk("lenbig_busy", busy, 0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 48);
            c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            rand_data(n);
            load(n);
            run("rand", n, 8'($urandom), c, 0, 1'b0);
        end

        // full-depth message
        rand_data(MAXL);
        load(MAXL);
        run("maxlen", MAXL, 8'($urandom), -1, 0, 1'b0);

        // reset in the middle of ENC
        rand_data(8);
        load(8);
        @(negedge clk); msg_len = (AW+1)'(8); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (!plain_in_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_reach_enc", plain_in_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid,
                                cipher_in, busy, pass, fail}, 0);
        chk("rst_mid_mcnt", mismatch_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {key_valid, busy}, 0);

        n = $urandom_range(1, 16);
        rand_data(n);
        load(n);
        run("after_rst", n, 8'($urandom), -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rc4_host.md
Name: rc4_host

Overview:
- Host-side controller for the RC4 core's byte-stream interface: the opposite end of every handshake the core uses.
- Streams a 32-byte key into the core, serves plaintext bytes on `plain_read`, and captures ciphertext from `cipher_write` into an internal buffer.
- Replays the buffered ciphertext on `cipher_read`, captures the recovered plaintext from `plain_write`, compares it byte-for-byte with the original message, and reports pass or fail.
- Used as a synthesizable self-check harness on FPGA and as the reusable stimulus/checker engine in simulation.

Parameters:
- KEY_LEN, 32, key bytes sent per run; must match the core's key register file.
- MAX_LEN, 2048, message buffer depth in bytes.
- ADDR_W, 11, index width; clog2(MAX_LEN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe; honoured only in IDLE
- cfg_sel  in  1  config target: 0 = key RAM, 1 = message RAM
- cfg_addr  in  ADDR_W  config byte address
- cfg_wdata  in  8  config byte
- msg_len  in  ADDR_W+1  message length, 1..MAX_LEN; sampled on start
- start  in  1  one-cycle pulse that begins a run
- key_valid  out  1  key byte valid (to core)
- key_in  out  8  key byte
- plain_in_valid  out  1  plaintext byte available
- plain_in  out  8  plaintext byte
- plain_read  in  1  core consumed the current plaintext byte
- cipher_write  in  1  core presents a ciphertext byte
- cipher_out  in  8  ciphertext byte
- cipher_in_valid  out  1  ciphertext byte available
- cipher_in  out  8  ciphertext byte
- cipher_read  in  1  core consumed the current ciphertext byte
- plain_write  in  1  core presents a recovered plaintext byte
- plain_out  in  8  recovered plaintext byte
- done  in  1  core finished decode
- busy  out  1  run in progress
- pass  out  1  sticky: run completed with zero mismatches
- fail  out  1  sticky: mismatch, overflow or timeout
- mismatch_cnt  out  ADDR_W+1  count of mismatching bytes, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; pointers and counters 0. Buffer RAM contents are not reset.
  - Reset asserted mid-run aborts the run immediately.
  - Data outputs (`key_in`, `plain_in`, `cipher_in`) read 0 on the cycle after reset.
- IDLE: `cfg_we` writes the selected RAM. `start` latches `msg_len`, clears `pass`/`fail`/`mismatch_cnt` and the pointers, sets `busy`, and moves to KEY.
  - `start` with `msg_len` == 0 or > MAX_LEN: set `fail` next cycle and stay in IDLE.
- KEY: `key_valid` = 1 for exactly KEY_LEN consecutive cycles, with `key_in` = key[k], k = 0..KEY_LEN-1, registered. Then `key_valid` drops and the state moves to ENC.
- ENC:
  - `plain_in_valid` = (rd_ptr < len); `plain_in` = msg[rd_ptr], registered.
  - `plain_read` sampled high while valid: rd_ptr increments, and the new byte appears on the next cycle.
  - `plain_read` while not valid is ignored.
  - `cipher_write`: cbuf[wr_ptr] <= `cipher_out`; wr_ptr increments.
  - `cipher_write` with wr_ptr == len: byte dropped, `fail` set.
  - When wr_ptr == len and rd_ptr == len: reset both pointers and go to DEC.
- DEC: same rules, using `cipher_in_valid`/`cipher_in` sourced from cbuf, `cipher_read`, and `plain_write`/`plain_out`.
  - Each captured byte is compared with msg[wr_ptr]. On inequality, `mismatch_cnt` increments (saturating) and `fail` is set.
- `done` sampled high in DEC moves to FIN. `done` in any other state is ignored.
- FIN (one cycle):
  - If wr_ptr != len, set `fail` (short decode).
  - `pass` = !`fail`.
  - `busy` = 0; return to IDLE.
- Same-cycle read and write strobes are both honoured; the pointers are independent.
- `start` while busy is ignored.

Optional Feature:
- Macro RC4_HOST_TIMEOUT_EN.
- Defined: a 20-bit watchdog counter clears on every handshake event (`plain_read`, `cipher_write`, `cipher_read`, `plain_write`, `done`). If it reaches 0xFFFFF in KEY/ENC/DEC, the block sets `fail`, moves to FIN and flags a timeout (reported via `fail`).
- Not defined: no counter; the block waits indefinitely.

Decomposition:
- Package rc4_host_pkg: state enum (IDLE, KEY, ENC, DEC, FIN), KEY_LEN, MAX_LEN, watchdog limit.
- One sub-module, rc4_host_byte_ram: single-write, single-registered-read byte RAM. It is instantiated three times: key, msg and cbuf.

Test Plan:
- Key stream: load key bytes 0x00..0x1F, start with `msg_len` = 4 → `key_valid` high for exactly 32 cycles with `key_in` = 0x00..0x1F in order.
- Loopback pass: stub core XORs each byte with 0x5A; msg = 0x11,0x22,0x33,0x44 → cbuf = 0x4B,0x78,0x69,0x1E; after `done`, `pass` = 1, `mismatch_cnt` = 0.
- Corruption: stub flips bit 0 of the 3rd decoded byte → `fail` = 1, `mismatch_cnt` = 1, `pass` = 0.
- Overflow: `msg_len` = 2, stub issues 3 `cipher_write` pulses → 3rd byte dropped, `fail` = 1.
- Bad config: `start` with `msg_len` = 0 → `fail` = 1, `busy` remains 0, state remains IDLE; rst pulse mid-ENC → all outputs 0 on the next cycle.
- With RC4_HOST_TIMEOUT_EN: stub stalls in ENC → `fail` = 1 after 0xFFFFF idle cycles, `busy` = 0.
